// File: rtl/vga_pkg.sv
// Shared raster timing for the display pipeline: 640x480 defaults, derived totals
// and the visible window that the pixel painters also test against.
package vga_pkg;

   localparam int COUNT_W = 10;

   localparam int CLK_DIV = 4;
   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_VIS   = 640;
   localparam int H_FRONT = 16;
   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 33;
   localparam int V_VIS   = 480;
   localparam int V_FRONT = 10;

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VIS + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VIS + V_FRONT;

   // Visible window bounds: START is the first visible count, END is one past the last.
   localparam int H_VIS_START = H_SYNC + H_BACK;
   localparam int H_VIS_END   = H_VIS_START + H_VIS;
   localparam int V_VIS_START = V_SYNC + V_BACK;
   localparam int V_VIS_END   = V_VIS_START + V_VIS;

   typedef logic [COUNT_W-1:0] count_t;

   function automatic logic in_span(input count_t c, input count_t lo, input count_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel-rate enable: one system-clock pulse every CLK_DIV clocks (CLK_DIV in 1..16).
module pix_clk_en #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic en
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] div_q;
   logic [3:0] div_d;

   // With CLK_DIV=1 the counter sits at 0 and the enable stays high.
   assign en = (div_q == DIV_LAST);

   always_comb begin
      div_d = en ? 4'd0 : div_q + 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) div_q <= 4'd0;
      else      div_q <= div_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter: hCount/vCount advance at the pixel rate; sync, bright and the
// tick/frame pulses are registered from the next counts so they change together.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = vga_pkg::CLK_DIV,
   parameter int H_SYNC  = vga_pkg::H_SYNC,
   parameter int H_BACK  = vga_pkg::H_BACK,
   parameter int H_VIS   = vga_pkg::H_VIS,
   parameter int H_FRONT = vga_pkg::H_FRONT,
   parameter int V_SYNC  = vga_pkg::V_SYNC,
   parameter int V_BACK  = vga_pkg::V_BACK,
   parameter int V_VIS   = vga_pkg::V_VIS,
   parameter int V_FRONT = vga_pkg::V_FRONT
) (
   input  logic               clk,
   input  logic               rst,
   output logic [COUNT_W-1:0] hCount,
   output logic [COUNT_W-1:0] vCount,
   output logic               hSync,
   output logic               vSync,
   output logic               bright,
   output logic               pix_tick,
   output logic               frame_start
);

   localparam int H_TOT = H_SYNC + H_BACK + H_VIS + H_FRONT;
   localparam int V_TOT = V_SYNC + V_BACK + V_VIS + V_FRONT;

   localparam count_t H_LAST     = count_t'(H_TOT - 1);
   localparam count_t V_LAST     = count_t'(V_TOT - 1);
   localparam count_t H_SYNC_END = count_t'(H_SYNC);
   localparam count_t V_SYNC_END = count_t'(V_SYNC);
   localparam count_t H_VIS_LO   = count_t'(H_SYNC + H_BACK);
   localparam count_t H_VIS_HI   = count_t'(H_SYNC + H_BACK + H_VIS);
   localparam count_t V_VIS_LO   = count_t'(V_SYNC + V_BACK);
   localparam count_t V_VIS_HI   = count_t'(V_SYNC + V_BACK + V_VIS);

   logic   pix_en;
   count_t h_q, h_d;
   count_t v_q, v_d;
   logic   hsync_q, hsync_d;
   logic   vsync_q, vsync_d;
   logic   bright_q, bright_d;
   logic   tick_q;
   logic   frame_q, frame_d;

   pix_clk_en #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_clk_en (
      .clk (clk),
      .rst (rst),
      .en  (pix_en)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      h_d = h_q;
      v_d = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
      // Decoded from the next counts so the registered flags line up with the counters.
      hsync_d  = (h_d >= H_SYNC_END);
      vsync_d  = (v_d >= V_SYNC_END);
      bright_d = in_span(h_d, H_VIS_LO, H_VIS_HI) && in_span(v_d, V_VIS_LO, V_VIS_HI);
      frame_d  = pix_en && (h_d == '0) && (v_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q      <= '0;
         v_q      <= '0;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
         bright_q <= 1'b0;
         tick_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         bright_q <= bright_d;
         tick_q   <= pix_en;
         frame_q  <= frame_d;
      end
   end

   assign hCount      = h_q;
   assign vCount      = v_q;
   assign hSync       = hsync_q;
   assign vSync       = vsync_q;
   assign bright      = bright_q;
   assign pix_tick    = tick_q;
   assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a shrunken raster at
// CLK_DIV=4 and at CLK_DIV=1, each checked every clock against a closed-form model.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       br;
      logic       pt;
      logic       fs;
   } obs_t;

   typedef struct {
      int div; int hs; int hb; int hv; int hf;
      int vs;  int vb; int vv; int vf;
   } geom_t;

   typedef struct {
      int   h;
      int   v;
      logic hs;
      logic vs;
      logic br;
   } vec_t;

   // Shrunken raster: 17 pixels x 11 lines, visible h 7..14, v 4..8.
   localparam int SD  = 4;
   localparam int SHS = 4;
   localparam int SHB = 3;
   localparam int SHV = 8;
   localparam int SHF = 2;
   localparam int SVS = 2;
   localparam int SVB = 2;
   localparam int SVV = 5;
   localparam int SVF = 2;
   localparam int SHT = SHS + SHB + SHV + SHF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [9:0] def_h, def_v, s_h, s_v, o_h, o_v;
   logic def_hs, def_vs, def_br, def_pt, def_fs;
   logic s_hs, s_vs, s_br, s_pt, s_fs;
   logic o_hs, o_vs, o_br, o_pt, o_fs;

   vga_timing_gen u_def (
      .clk (clk), .rst (rst), .hCount (def_h), .vCount (def_v), .hSync (def_hs),
      .vSync (def_vs), .bright (def_br), .pix_tick (def_pt), .frame_start (def_fs)
   );

   vga_timing_gen #(
      .CLK_DIV (SD), .H_SYNC (SHS), .H_BACK (SHB), .H_VIS (SHV), .H_FRONT (SHF),
      .V_SYNC (SVS), .V_BACK (SVB), .V_VIS (SVV), .V_FRONT (SVF)
   ) u_s (
      .clk (clk), .rst (rst), .hCount (s_h), .vCount (s_v), .hSync (s_hs),
      .vSync (s_vs), .bright (s_br), .pix_tick (s_pt), .frame_start (s_fs)
   );

   vga_timing_gen #(
      .CLK_DIV (1), .H_SYNC (SHS), .H_BACK (SHB), .H_VIS (SHV), .H_FRONT (SHF),
      .V_SYNC (SVS), .V_BACK (SVB), .V_VIS (SVV), .V_FRONT (SVF)
   ) u_one (
      .clk (clk), .rst (rst), .hCount (o_h), .vCount (o_v), .hSync (o_hs),
      .vSync (o_vs), .bright (o_br), .pix_tick (o_pt), .frame_start (o_fs)
   );

   obs_t act_def, act_s, act_o;
   assign act_def = {def_h, def_v, def_hs, def_vs, def_br, def_pt, def_fs};
   assign act_s   = {s_h, s_v, s_hs, s_vs, s_br, s_pt, s_fs};
   assign act_o   = {o_h, o_v, o_hs, o_vs, o_br, o_pt, o_fs};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs after n clock edges since reset release, from the frame position alone.
   function automatic obs_t model(input int n, input geom_t g);
      obs_t e;
      int ht, vt, pos, h, v;
      ht  = g.hs + g.hb + g.hv + g.hf;
      vt  = g.vs + g.vb + g.vv + g.vf;
      pos = (n / g.div) % (ht * vt);
      h   = pos % ht;
      v   = pos / ht;
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.hs = (h >= g.hs);
      e.vs = (v >= g.vs);
      e.br = (h >= g.hs + g.hb) && (h < g.hs + g.hb + g.hv) &&
             (v >= g.vs + g.vb) && (v < g.vs + g.vb + g.vv);
      e.pt = (n > 0) && (n % g.div == 0);
      e.fs = e.pt && (pos == 0);
      return e;
   endfunction

   geom_t g_def, g_s, g_o;
   int    n;
   obs_t  q_def[$];
   obs_t  q_s[$];
   obs_t  q_o[$];

   // Each edge pushes what the DUTs must show; the following falling edge pops and compares.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n <= 0;
         q_def.delete();
         q_s.delete();
         q_o.delete();
      end else begin
         n <= n + 1;
         q_def.push_back(model(n + 1, g_def));
         q_s.push_back(model(n + 1, g_s));
         q_o.push_back(model(n + 1, g_o));
      end
   end

   always @(negedge clk) begin
      if (q_def.size() > 0) check("sb_def", 32'(act_def), 32'(q_def.pop_front()));
      if (q_s.size() > 0)   check("sb_small", 32'(act_s), 32'(q_s.pop_front()));
      if (q_o.size() > 0)   check("sb_div1", 32'(act_o), 32'(q_o.pop_front()));
   end

   task automatic wait_n(input int target);
      int i;
      i = 0;
      while (n < target && i < 100000) begin
         @(negedge clk);
         i++;
      end
      if (n != target) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_n: reached edge %0d, required %0d", n, target);
      end
   endtask

   vec_t tbl[12];

   initial begin
      int c;
      g_def = '{4, 96, 48, 640, 16, 2, 33, 480, 10};
      g_s   = '{SD, SHS, SHB, SHV, SHF, SVS, SVB, SVV, SVF};
      g_o   = '{1, SHS, SHB, SHV, SHF, SVS, SVB, SVV, SVF};

      tbl[0]  = '{3,  0,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4,  0,  1'b1, 1'b0, 1'b0};
      tbl[2]  = '{16, 1,  1'b1, 1'b0, 1'b0};
      tbl[3]  = '{0,  2,  1'b0, 1'b1, 1'b0};
      tbl[4]  = '{7,  3,  1'b1, 1'b1, 1'b0};
      tbl[5]  = '{6,  4,  1'b1, 1'b1, 1'b0};
      tbl[6]  = '{7,  4,  1'b1, 1'b1, 1'b1};
      tbl[7]  = '{14, 4,  1'b1, 1'b1, 1'b1};
      tbl[8]  = '{15, 4,  1'b1, 1'b1, 1'b0};
      tbl[9]  = '{14, 8,  1'b1, 1'b1, 1'b1};
      tbl[10] = '{7,  9,  1'b1, 1'b1, 1'b0};
      tbl[11] = '{16, 10, 1'b1, 1'b1, 1'b0};

      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_def", 32'(act_def), 32'd0);
      check("reset_small", 32'(act_s), 32'd0);
      check("reset_div1", 32'(act_o), 32'd0);
      rst = 1'b1;

      // First advance of the default raster lands exactly on the fourth edge.
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("release_hcount", 32'(def_h), (k >= 4) ? 32'd1 : 32'd0);
         check("release_tick", 32'(def_pt), (k == 4) ? 32'd1 : 32'd0);
         check("release_hsync", 32'(def_hs), 32'd0);
         check("release_bright", 32'(def_br), 32'd0);
      end

      for (int i = 0; i < 12; i++) begin
         wait_n((tbl[i].v * SHT + tbl[i].h) * SD + 1);
         check($sformatf("window_vec%0d", i), 32'({s_h, s_v, s_hs, s_vs, s_br}),
               32'({10'(tbl[i].h), 10'(tbl[i].v), tbl[i].hs, tbl[i].vs, tbl[i].br}));
      end

      c = 0;
      while (!s_fs && c < 2000) begin @(negedge clk); c++; end
      check("frame_seen_small", 32'(s_fs), 32'd1);
      c = 0;
      do begin @(negedge clk); c++; end while (!s_fs && c < 2000);
      check("frame_period_small", c, 32'd748);

      c = 0;
      while (!o_fs && c < 2000) begin @(negedge clk); c++; end
      check("frame_seen_div1", 32'(o_fs), 32'd1);
      c = 0;
      do begin @(negedge clk); c++; end while (!o_fs && c < 2000);
      check("frame_period_div1", c, 32'd187);

      // Default raster across the end of line 10 and the hSync edge of line 11.
      wait_n((10 * 800 + 799) * 4 + 1);
      check("line10_end", 32'({def_h, def_v}), 32'({10'd799, 10'd10}));
      wait_n((11 * 800) * 4 + 1);
      check("line11_start", 32'({def_h, def_v, def_hs}), 32'({10'd0, 10'd11, 1'b0}));
      wait_n((11 * 800 + 95) * 4 + 1);
      check("hsync_last_low", 32'(def_hs), 32'd0);
      wait_n((11 * 800 + 96) * 4 + 1);
      check("hsync_first_high", 32'(def_hs), 32'd1);

      // Mid-frame asynchronous reset, applied away from any clock edge.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_reset_def", 32'(act_def), 32'd0);
      check("async_reset_small", 32'(act_s), 32'd0);
      check("async_reset_div1", 32'(act_o), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_hold_small", 32'(act_s), 32'd0);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("restart_small_h", 32'(s_h), (k == 4) ? 32'd1 : 32'd0);
         check("restart_div1_h", 32'(o_h), 32'(k));
      end

      repeat (200) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
